// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel clock divider, h/v counters, line/frame strobes,
// and sync/blank decodes delayed by SYNC_DLY pixel periods to match the colour stage latency.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_DLY = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic       VGA_CLK,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_en,
    output logic       line_start,
    output logic       frame_start,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             hs_raw;
    logic             vs_raw;
    logic             act_raw;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + DIV_ONE;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    // VGA_CLK is low for the first half-pixel so its rising edge lands mid-pixel
    assign pix_en      = (div_cnt == DIV_LAST);
    assign VGA_CLK     = (div_cnt >= DIV_HALF);
    assign x           = h_cnt;
    assign y           = v_cnt;
    assign line_start  = pix_en && (h_cnt == H_LAST);
    assign frame_start = line_start && (v_cnt == V_LAST);
    assign VGA_SYNC_N  = 1'b0;

    assign hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign act_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    generate
        if (SYNC_DLY == 0) begin : g_no_dly
            assign VGA_HS      = hs_raw;
            assign VGA_VS      = vs_raw;
            assign VGA_BLANK_N = act_raw;
        end else begin : g_dly
            logic [SYNC_DLY-1:0] hs_sr;
            logic [SYNC_DLY-1:0] vs_sr;
            logic [SYNC_DLY-1:0] act_sr;

            // reset flushes the line so no partial sync pulse survives
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    hs_sr  <= '1;
                    vs_sr  <= '1;
                    act_sr <= '0;
                end else if (pix_en) begin
                    hs_sr[0]  <= hs_raw;
                    vs_sr[0]  <= vs_raw;
                    act_sr[0] <= act_raw;
                    for (int i = 1; i < SYNC_DLY; i++) begin
                        hs_sr[i]  <= hs_sr[i-1];
                        vs_sr[i]  <= vs_sr[i-1];
                        act_sr[i] <= act_sr[i-1];
                    end
                end
            end

            assign VGA_HS      = hs_sr[SYNC_DLY-1];
            assign VGA_VS      = vs_sr[SYNC_DLY-1];
            assign VGA_BLANK_N = act_sr[SYNC_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default-geometry instance plus two reduced-geometry
// instances (SYNC_DLY 0 and 3), checked cycle by cycle against a closed-form raster model.
module tb_vga_timing_gen;

    localparam int NCYC = 20000;

    typedef struct {
        int t;
        int x;
        int y;
        bit vclk;
        bit pe;
        bit ls;
        bit fs;
        bit hs;
        bit vs;
        bit bn;
    } exp_t;

    // instance 0: default geometry, 1: small/DLY0/DIV2, 2: small/DLY3/DIV4
    int p_ha[3]  = '{640, 16, 16};
    int p_hf[3]  = '{16, 2, 2};
    int p_hsw[3] = '{96, 4, 4};
    int p_hb[3]  = '{48, 3, 3};
    int p_va[3]  = '{480, 8, 8};
    int p_vf[3]  = '{10, 2, 2};
    int p_vsw[3] = '{2, 2, 2};
    int p_vb[3]  = '{33, 3, 3};
    int p_div[3] = '{2, 2, 4};
    int p_dly[3] = '{1, 0, 3};

    logic CLK;
    logic RST_N;

    logic       vclk[3], pe[3], ls[3], fs[3], hs[3], vs[3], bn[3], sn[3];
    logic [9:0] xo[3], yo[3];

    int checks;
    int failures;
    int n_meas;
    int cyc;
    int t_model;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    vga_timing_gen u_def (
        .CLK(CLK), .RST_N(RST_N), .VGA_CLK(vclk[0]), .x(xo[0]), .y(yo[0]),
        .pix_en(pe[0]), .line_start(ls[0]), .frame_start(fs[0]),
        .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bn[0]), .VGA_SYNC_N(sn[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(2), .SYNC_DLY(0)
    ) u_s0 (
        .CLK(CLK), .RST_N(RST_N), .VGA_CLK(vclk[1]), .x(xo[1]), .y(yo[1]),
        .pix_en(pe[1]), .line_start(ls[1]), .frame_start(fs[1]),
        .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bn[1]), .VGA_SYNC_N(sn[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(4), .SYNC_DLY(3)
    ) u_s3 (
        .CLK(CLK), .RST_N(RST_N), .VGA_CLK(vclk[2]), .x(xo[2]), .y(yo[2]),
        .pix_en(pe[2]), .line_start(ls[2]), .frame_start(fs[2]),
        .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_BLANK_N(bn[2]), .VGA_SYNC_N(sn[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Raster position follows purely from clocks elapsed since the last reset edge.
    function automatic exp_t model(input int k, input int t);
        exp_t e;
        int ht, vt, p, ph, q, qx, qy;
        ht = p_ha[k] + p_hf[k] + p_hsw[k] + p_hb[k];
        vt = p_va[k] + p_vf[k] + p_vsw[k] + p_vb[k];
        p  = t / p_div[k];
        ph = t % p_div[k];
        e.t    = t;
        e.x    = p % ht;
        e.y    = (p / ht) % vt;
        e.pe   = (ph == p_div[k] - 1);
        e.vclk = (ph >= p_div[k] / 2);
        e.ls   = e.pe && (e.x == ht - 1);
        e.fs   = e.ls && (e.y == vt - 1);
        q = p - p_dly[k];
        if (q < 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.bn = 1'b0;
        end else begin
            qx = q % ht;
            qy = (q / ht) % vt;
            e.hs = !(qx >= p_ha[k] + p_hf[k] && qx < p_ha[k] + p_hf[k] + p_hsw[k]);
            e.vs = !(qy >= p_va[k] + p_vf[k] && qy < p_va[k] + p_vf[k] + p_vsw[k]);
            e.bn = (qx < p_ha[k]) && (qy < p_va[k]);
        end
        return e;
    endfunction

    task automatic push_all(input int t);
        q0.push_back(model(0, t));
        q1.push_back(model(1, t));
        q2.push_back(model(2, t));
    endtask

    task automatic cmp(input int k, input exp_t e);
        checks++;
        if (xo[k] !== 10'(e.x) || yo[k] !== 10'(e.y) || vclk[k] !== e.vclk || pe[k] !== e.pe ||
            ls[k] !== e.ls || fs[k] !== e.fs || hs[k] !== e.hs || vs[k] !== e.vs ||
            bn[k] !== e.bn || sn[k] !== 1'b0) begin
            failures++;
            $display("FAIL raster inst%0d t=%0d got x=%0d y=%0d clk=%b pe=%b ls=%b fs=%b hs=%b vs=%b bn=%b sn=%b want x=%0d y=%0d clk=%b pe=%b ls=%b fs=%b hs=%b vs=%b bn=%b sn=0",
                     k, e.t, xo[k], yo[k], vclk[k], pe[k], ls[k], fs[k], hs[k], vs[k], bn[k], sn[k],
                     e.x, e.y, e.vclk, e.pe, e.ls, e.fs, e.hs, e.vs, e.bn);
        end
    endtask

    task automatic chk(input int k, input string nm, input int got, input int want);
        checks++;
        n_meas++;
        if (got != want) begin
            failures++;
            $display("FAIL %s inst%0d cyc=%0d got=%0d want=%0d", nm, k, cyc, got, want);
        end
    endtask

    int ls_last[3], fs_last[3], hsf[3], vsf[3], xh[3], x0[3], bcnt[3], lcnt[3];
    bit bvalid[3], lvalid[3];
    logic prev_bn[3], prev_hs[3], prev_vs[3];
    int prev_x[3];

    // Interval measurements against the timing figures derived from the geometry.
    task automatic measure(input int k, input exp_t e);
        int ht, vt, hss;
        ht  = p_ha[k] + p_hf[k] + p_hsw[k] + p_hb[k];
        vt  = p_va[k] + p_vf[k] + p_vsw[k] + p_vb[k];
        hss = p_ha[k] + p_hf[k];
        if (e.t == 0) begin
            ls_last[k] = -1; fs_last[k] = -1; hsf[k] = -1; vsf[k] = -1;
            xh[k] = -1; x0[k] = -1; bcnt[k] = 0; lcnt[k] = 0;
            bvalid[k] = 1'b0; lvalid[k] = 1'b0;
        end
        if (xo[k] == 10'(hss) && prev_x[k] != hss) xh[k] = cyc;
        if (xo[k] == 10'd0 && (prev_x[k] != 0 || e.t == 0)) x0[k] = cyc;
        if (pe[k] && bn[k]) begin
            bcnt[k]++;
            lcnt[k]++;
        end
        if (ls[k]) begin
            if (ls_last[k] >= 0) chk(k, "line_period", cyc - ls_last[k], ht * p_div[k]);
            if (lvalid[k]) chk(k, "line_blank", lcnt[k], (e.y < p_va[k]) ? p_ha[k] : 0);
            ls_last[k] = cyc;
            lcnt[k] = 0;
            lvalid[k] = 1'b1;
        end
        if (fs[k]) begin
            if (fs_last[k] >= 0) chk(k, "frame_period", cyc - fs_last[k], ht * vt * p_div[k]);
            if (bvalid[k]) chk(k, "frame_blank", bcnt[k], p_ha[k] * p_va[k]);
            fs_last[k] = cyc;
            bcnt[k] = 0;
            bvalid[k] = 1'b1;
        end
        if (prev_hs[k] === 1'b1 && hs[k] === 1'b0) begin
            if (xh[k] >= 0) chk(k, "hs_delay", cyc - xh[k], p_dly[k] * p_div[k]);
            hsf[k] = cyc;
        end
        if (prev_hs[k] === 1'b0 && hs[k] === 1'b1 && e.t != 0 && hsf[k] >= 0)
            chk(k, "hs_low", cyc - hsf[k], p_hsw[k] * p_div[k]);
        if (prev_vs[k] === 1'b1 && vs[k] === 1'b0) vsf[k] = cyc;
        if (prev_vs[k] === 1'b0 && vs[k] === 1'b1 && e.t != 0 && vsf[k] >= 0)
            chk(k, "vs_low", cyc - vsf[k], p_vsw[k] * ht * p_div[k]);
        if (prev_bn[k] !== 1'b1 && bn[k] === 1'b1 && x0[k] >= 0)
            chk(k, "blank_rise", cyc - x0[k], p_dly[k] * p_div[k]);
        prev_x[k]  = int'(xo[k]);
        prev_hs[k] = hs[k];
        prev_vs[k] = vs[k];
        prev_bn[k] = bn[k];
    endtask

    initial begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            prev_x[k] = 0; prev_hs[k] = 1'b1; prev_vs[k] = 1'b1; prev_bn[k] = 1'b0;
            ls_last[k] = -1; fs_last[k] = -1; hsf[k] = -1; vsf[k] = -1;
            xh[k] = -1; x0[k] = -1; bcnt[k] = 0; lcnt[k] = 0;
            bvalid[k] = 1'b0; lvalid[k] = 1'b0;
        end
        forever begin
            @(negedge CLK);
            if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty cyc=%0d got sizes=%0d/%0d/%0d want nonzero",
                         cyc, q0.size(), q1.size(), q2.size());
            end else begin
                e = q0.pop_front(); cmp(0, e); measure(0, e);
                e = q1.pop_front(); cmp(1, e); measure(1, e);
                e = q2.pop_front(); cmp(2, e); measure(2, e);
            end
            cyc++;
        end
    end

    initial begin
        int pulse;
        checks = 0;
        failures = 0;
        n_meas = 0;
        cyc = 0;
        pulse = 0;
        RST_N = 1'b0;
        t_model = 0;
        push_all(t_model);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge CLK);
            #2;
            if (c < 4) begin
                RST_N = 1'b0;
            end else if (c < 6000) begin
                RST_N = 1'b1;
            end else begin
                if (pulse == 0 && $urandom_range(2499, 0) == 0) pulse = $urandom_range(3, 1);
                if (pulse > 0) begin
                    RST_N = 1'b0;
                    pulse--;
                end else begin
                    RST_N = 1'b1;
                end
            end
            t_model = RST_N ? t_model + 1 : 0;
            push_all(t_model);
        end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (n_meas < 20) begin
            failures++;
            $display("FAIL measurements_seen got=%0d want>=20", n_meas);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
